led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised successor to the board's free-running LED blink counter.
- Drives N_LEDS outputs with one of four selectable patterns: binary count, bounce scan, blink-all, Gray count.
- Step rate comes from an on-chip prescaler plus a 4-level speed select; two debounced push-buttons cycle the mode and the speed.
- Top-level block between the board clock/buttons and the LED pins.

Parameters:
- N_LEDS, 4: number of LED outputs (1..16).
- PRESC_DIV, 131072: PCLK cycles per base tick (>=2).
- DEB_CYCLES, 4000: consecutive cycles of disagreement before a button's debounced level changes (>=1).

Ports:
- PCLK  in  1  board clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- BTN_MODE  in  1  raw mode button, asynchronous to PCLK, active-high.
- BTN_SPEED  in  1  raw speed button, asynchronous to PCLK, active-high.
- LD  out  N_LEDS  LED drive, 1 = on.
- MODE  out  2  current mode (0 binary, 1 scan, 2 blink, 3 Gray).
- SPEED  out  2  current speed (0 fastest).

Behaviour:
- Clocking and reset:
  - One clock, PCLK.
  - RST asynchronous, active-high; all registers clear immediately on assertion.
  - After reset: MODE=0, SPEED=0, LD=0, count=0, pos=0, dir=up, phase=0, prescaler=0, speed counter=0, debouncers stable=0.
- Debounce, per button:
  - 2-flop synchronizer feeds a counter.
  - Counter clears when the synced value equals the stable value; otherwise it increments.
  - On the DEB_CYCLES-th consecutive disagreeing cycle, stable takes the synced value and the counter clears.
  - A press is a stable 0->1 transition, one-cycle pulse; releases produce nothing.
  - MODE/SPEED update exactly DEB_CYCLES+3 rising edges after the first edge that samples the button high, provided the button is held.
- Tick generation:
  - Prescaler counts 0..PRESC_DIV-1 and emits base_tick on the wrap cycle.
  - Speed counter counts base_ticks; step fires on the base_tick where speed counter == 2^SPEED-1, then the speed counter clears.
  - Step period = PRESC_DIV * 2^SPEED cycles.
- Pattern state, updated on step:
  - Mode 0: count <= count+1 mod 2^N_LEDS; LD = count.
  - Mode 1:
    - pos moves by dir; reverses at N_LEDS-1 and at 0.
    - Sequence for N=4: 0,1,2,3,2,1,0,1...
    - LD = one-hot(pos); N_LEDS=1 holds pos 0.
  - Mode 2: phase toggles; LD = all ones when phase=1, else 0.
  - Mode 3: count increments as in mode 0; LD = count ^ (count>>1).
  - LD is combinational from registered state, no extra latency.
- Mode press:
  - MODE <= MODE+1 mod 4.
  - Same edge: count, pos, dir, phase, prescaler and speed counter clear.
  - Wins over a coincident step, which is discarded.
- Speed press:
  - SPEED <= SPEED+1 mod 4.
  - Prescaler and speed counter clear; pattern state is kept.
  - A coincident step is discarded.
- Simultaneous mode and speed press: both apply on the same edge.
- Reset mid-debounce or mid-step: all progress is lost; no pulse is generated for a button already held when RST deasserts until it is released and pressed again.

Optional Feature:
- LED_PWM_DIM_EN defined:
  - Free-running 4-bit PWM counter, reset 0.
  - Each LD bit = pattern bit AND (pwm < 4), giving 25% brightness.
  - Pattern timing unchanged.
- Not defined: LD = pattern directly and no PWM counter is present.

Test Plan:
- Bench parameters: N_LEDS=4, PRESC_DIV=4, DEB_CYCLES=3, unless noted.
- Reset then run 64 cycles at SPEED=0 -> LD steps every 4 cycles 0,1,2,...,15,0; wraps after 64 cycles.
- Hold BTN_MODE high from edge k -> MODE=1 at edge k+6, LD=0001; then at 4-cycle steps 0010,0100,1000,0100,0010,0001.
- Pulse BTN_MODE high for 2 cycles only (bounce) -> MODE stays 0; a 3rd consecutive pulse of 3+ cycles still needs full DEB_CYCLES before MODE changes.
- Press BTN_SPEED once in mode 0 with count=5 -> SPEED=1, count still 5, next step exactly 8 cycles later; SPEED wraps 3->0 after 4 presses.
- Mode 3 -> LD sequence 0000,0001,0011,0010,0110; assert RST mid-sequence -> LD=0000, MODE=0, SPEED=0 asynchronously, before the next PCLK edge.
- With LED_PWM_DIM_EN in mode 2 phase 1 -> each LD bit high 4 of every 16 cycles; without the macro, steady 1111.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-pattern LED driver: binary, bounce scan, blink-all and Gray count, with debounced mode/speed buttons.
// Define LED_PWM_DIM_EN to dim every LED to 25% duty through a free-running 4-bit PWM counter.

module led_pattern_gen_debounce #(
  parameter int unsigned DEB_CYCLES = 4000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1, sync2, stable, stable_d, armed;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;

  // armed stays low until a released button is seen after reset, so a button
  // held through reset cannot produce a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      fill     <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      armed    <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      fill     <= {fill[0], 1'b1};
      stable_d <= stable;
      press    <= stable & ~stable_d & armed;
      if (fill[1] && !sync2 && !stable)
        armed <= 1'b1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module led_pattern_gen #(
  parameter int unsigned N_LEDS     = 4,
  parameter int unsigned PRESC_DIV  = 131072,
  parameter int unsigned DEB_CYCLES = 4000
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              BTN_MODE,
  input  logic              BTN_SPEED,
  output logic [N_LEDS-1:0] LD,
  output logic [1:0]        MODE,
  output logic [1:0]        SPEED
);
  localparam int unsigned PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int unsigned SW = $clog2(PRESC_DIV);
  localparam logic [PW-1:0]     POS_MAX   = PW'(N_LEDS - 1);
  localparam logic [SW-1:0]     PRESC_MAX = SW'(PRESC_DIV - 1);
  localparam logic [N_LEDS-1:0] LED_ONE   = N_LEDS'(1);

  typedef enum logic [1:0] {MODE_BIN, MODE_SCAN, MODE_BLINK, MODE_GRAY} mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  mode_t             mode_q, mode_d;
  dir_t              dir_q, dir_d;
  logic [1:0]        speed_q, speed_d, mode_inc;
  logic [N_LEDS-1:0] count_q, count_d, pattern;
  logic [PW-1:0]     pos_q, pos_d;
  logic              phase_q, phase_d;
  logic [SW-1:0]     presc_q, presc_d;
  logic [2:0]        spd_cnt_q, spd_cnt_d, spd_last;
  logic              mode_press, speed_press, base_tick, step;

  led_pattern_gen_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(PCLK), .rst(RST), .btn(BTN_MODE), .press(mode_press)
  );
  led_pattern_gen_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
    .clk(PCLK), .rst(RST), .btn(BTN_SPEED), .press(speed_press)
  );

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      mode_q    <= MODE_BIN;
      speed_q   <= '0;
      count_q   <= '0;
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      phase_q   <= 1'b0;
      presc_q   <= '0;
      spd_cnt_q <= '0;
    end else begin
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      count_q   <= count_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      presc_q   <= presc_d;
      spd_cnt_q <= spd_cnt_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    speed_d   = speed_q;
    count_d   = count_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    phase_d   = phase_q;
    mode_inc  = mode_q + 2'd1;
    spd_last  = 3'd0;
    case (speed_q)
      2'd0: spd_last = 3'd0;
      2'd1: spd_last = 3'd1;
      2'd2: spd_last = 3'd3;
      default: spd_last = 3'd7;
    endcase
    base_tick = (presc_q == PRESC_MAX);
    step      = base_tick && (spd_cnt_q == spd_last);
    presc_d   = base_tick ? '0 : presc_q + 1'b1;
    if (step)
      spd_cnt_d = '0;
    else if (base_tick)
      spd_cnt_d = spd_cnt_q + 1'b1;
    else
      spd_cnt_d = spd_cnt_q;

    // any button press suppresses a step landing on the same edge
    if (step && !mode_press && !speed_press) begin
      case (mode_q)
        MODE_SCAN: begin
          if (N_LEDS > 1) begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_MAX) begin
                dir_d = DIR_DOWN;
                pos_d = pos_q - 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = pos_q + 1'b1;
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
          end
        end
        MODE_BLINK: phase_d = ~phase_q;
        default:    count_d = count_q + 1'b1;
      endcase
    end

    if (speed_press) begin
      speed_d   = speed_q + 2'd1;
      presc_d   = '0;
      spd_cnt_d = '0;
    end
    if (mode_press) begin
      mode_d    = mode_t'(mode_inc);
      count_d   = '0;
      pos_d     = '0;
      dir_d     = DIR_UP;
      phase_d   = 1'b0;
      presc_d   = '0;
      spd_cnt_d = '0;
    end
  end

  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_BIN:   pattern = count_q;
      MODE_SCAN:  pattern = LED_ONE << pos_q;
      MODE_BLINK: pattern = {N_LEDS{phase_q}};
      MODE_GRAY:  pattern = count_q ^ (count_q >> 1);
      default:    pattern = '0;
    endcase
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST)
      pwm_q <= '0;
    else
      pwm_q <= pwm_q + 4'd1;
  end

  assign LD = pattern & {N_LEDS{pwm_q < 4'd4}};
`else
  assign LD = pattern;
`endif

  assign MODE  = mode_q;
  assign SPEED = speed_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues cycle-tagged expectations, a negedge monitor checks them.

module tb_led_pattern_gen;
  logic       clk, RST, BTN_MODE, BTN_SPEED;
  logic [3:0] LD;
  logic [1:0] MODE, SPEED;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;

  typedef struct {
    int         when;
    string      name;
    logic [3:0] ld;
    logic [1:0] mode;
    logic [1:0] speed;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  led_pattern_gen #(.N_LEDS(4), .PRESC_DIV(4), .DEB_CYCLES(3)) dut (
    .PCLK(clk), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_SPEED(BTN_SPEED),
    .LD(LD), .MODE(MODE), .SPEED(SPEED)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      cur = sb.pop_front();
      compared++;
      if (cur.when != cyc || LD !== cur.ld || MODE !== cur.mode || SPEED !== cur.speed) begin
        mismatched++;
        $display("FAIL %s @cyc %0d (due %0d): got LD=%b MODE=%0d SPEED=%0d, want LD=%b MODE=%0d SPEED=%0d",
                 cur.name, cyc, cur.when, LD, MODE, SPEED, cur.ld, cur.mode, cur.speed);
      end
    end
  end

  task automatic push(input int when, input string name, input logic [3:0] ld,
                      input logic [1:0] mode, input logic [1:0] speed);
    exp_t e;
    e.when = when; e.name = name; e.ld = ld; e.mode = mode; e.speed = speed;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // button goes high 7 edges before the edge where the press must take effect
  task automatic press_speed(input int eff);
    goto(eff - 7); BTN_SPEED = 1'b1;
    goto(eff - 3); BTN_SPEED = 1'b0;
  endtask

  task automatic press_mode(input int eff);
    goto(eff - 7); BTN_MODE = 1'b1;
    goto(eff - 3); BTN_MODE = 1'b0;
  endtask

  int scan_pos[11] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
  logic [3:0] gray_seq[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};

  initial begin
    int c0, s, m1, p, b, g, r0;
    RST = 1'b1; BTN_MODE = 1'b0; BTN_SPEED = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, "reset_hold", 4'b0000, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    RST = 1'b0;
    c0 = cyc;

    push(c0, "reset_state", 4'b0000, 2'd0, 2'd0);
    for (int i = 1; i <= 16; i++) begin
      push(c0 + 4*i - 1, "bin_hold", 4'((i - 1) % 16), 2'd0, 2'd0);
      push(c0 + 4*i,     "bin_step", 4'(i % 16), 2'd0, 2'd0);
    end

    s = c0 + 86;
    push(s - 1,  "spd_pre",      4'd5, 2'd0, 2'd0);
    push(s,      "spd1_keep",    4'd5, 2'd0, 2'd1);
    push(s + 7,  "spd1_wait",    4'd5, 2'd0, 2'd1);
    push(s + 8,  "spd1_step",    4'd6, 2'd0, 2'd1);
    push(s + 15, "spd1_wait2",   4'd6, 2'd0, 2'd1);
    push(s + 16, "spd1_step2",   4'd7, 2'd0, 2'd1);
    press_speed(s);
    push(s + 23, "spd2_pre",     4'd7, 2'd0, 2'd1);
    push(s + 24, "spd2_nostep",  4'd7, 2'd0, 2'd2);
    push(s + 39, "spd2_wait",    4'd7, 2'd0, 2'd2);
    push(s + 40, "spd2_step",    4'd8, 2'd0, 2'd2);
    press_speed(s + 24);
    push(s + 59, "spd3_pre",     4'd9, 2'd0, 2'd2);
    push(s + 60, "spd3",         4'd9, 2'd0, 2'd3);
    push(s + 71, "spd3_wait",    4'd9, 2'd0, 2'd3);
    press_speed(s + 60);
    push(s + 72, "spd_wrap",     4'd9, 2'd0, 2'd0);
    push(s + 75, "spd0_wait",    4'd9, 2'd0, 2'd0);
    push(s + 76, "spd0_step",    4'd10, 2'd0, 2'd0);
    push(s + 80, "spd0_step2",   4'd11, 2'd0, 2'd0);
    press_speed(s + 72);

    m1 = s + 86;
    push(m1 - 1, "mode_pre", 4'd12, 2'd0, 2'd0);
    for (int j = 0; j <= 10; j++)
      push(m1 + 4*j, "scan", 4'b0001 << scan_pos[j], 2'd1, 2'd0);
    press_mode(m1);

    p = m1 + 30;
    b = m1 + 43;
    push(m1 + 42, "bounce_hold", 4'b0100, 2'd1, 2'd0);
    push(b,      "blink_enter",  4'b0000, 2'd2, 2'd0);
    push(b + 3,  "blink_off",    4'b0000, 2'd2, 2'd0);
    for (int j = 4; j <= 7; j++)
      push(b + j, "blink_on",    4'b1111, 2'd2, 2'd0);
    push(b + 8,  "blink_off2",   4'b0000, 2'd2, 2'd0);
    push(b + 12, "blink_on2",    4'b1111, 2'd2, 2'd0);
    goto(p);     BTN_MODE = 1'b1;
    goto(p + 2); BTN_MODE = 1'b0;
    goto(p + 3); BTN_MODE = 1'b1;
    goto(p + 5); BTN_MODE = 1'b0;
    goto(p + 6); BTN_MODE = 1'b1;
    goto(p + 9); BTN_MODE = 1'b0;

    g = b + 22;
    push(g - 1, "gray_pre", 4'b1111, 2'd2, 2'd0);
    for (int j = 0; j <= 4; j++)
      push(g + 4*j, "gray", gray_seq[j], 2'd3, 2'd0);
    push(g + 17, "gray_speed", 4'b0110, 2'd3, 2'd1);
    press_mode(g);
    press_speed(g + 17);

    goto(g + 18);
    RST = 1'b1;
    push(g + 18, "async_rst", 4'b0000, 2'd0, 2'd0);
    goto(g + 19); BTN_MODE = 1'b1;
    push(g + 20, "rst_btn_held", 4'b0000, 2'd0, 2'd0);
    goto(g + 21);
    RST = 1'b0;
    r0 = cyc;
    push(r0 + 10, "held_no_press",  4'b0010, 2'd0, 2'd0);
    push(r0 + 14, "held_no_press2", 4'b0011, 2'd0, 2'd0);
    goto(r0 + 14); BTN_MODE = 1'b0;
    push(r0 + 28, "repress_pre", 4'b0111, 2'd0, 2'd0);
    push(r0 + 29, "repress",     4'b0001, 2'd1, 2'd0);
    goto(r0 + 22); BTN_MODE = 1'b1;
    goto(r0 + 26); BTN_MODE = 1'b0;

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      mismatched += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, required 0", sb.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
